// File: rtl/temp_adc_encoder.sv
// SPI master for a 12-bit serial temperature ADC. Four conversions are averaged
// and quantized to a 3-bit code, with hysteresis applied at every code boundary.
module temp_adc_encoder #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int HYST          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic [2:0] temp,
  output logic       temp_valid,
  output logic       busy
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM, UPDATE} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [DW-1:0]   div_cnt;
  logic            div_last;
  logic            sclk_hi;
  logic [3:0]      bit_cnt;
  logic [11:0]     sr;
  logic [1:0]      smp_cnt;
  logic [13:0]     accum;
  logic [12:0]     avg13;
  logic [2:0]      c;
  logic [2:0]      temp_nx;

  assign tick     = (tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign div_last = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (tick) state_nx = CS_SETUP;
      CS_SETUP: if (div_last) state_nx = SHIFT;
      SHIFT:    if (div_last && sclk_hi && bit_cnt == 4'd15) state_nx = CS_HOLD;
      CS_HOLD:  if (div_last) state_nx = ACCUM;
      ACCUM:    state_nx = (smp_cnt == 2'd3) ? UPDATE : IDLE;
      UPDATE:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    cs_n = !(state == CS_SETUP || state == SHIFT || state == CS_HOLD);
    sclk = (state == SHIFT) && sclk_hi;
    busy = !cs_n;
  end

  // Average is the accumulator divided by four; 13 bits keeps avg+HYST from wrapping.
  assign avg13 = 13'(accum >> 2);
  assign c     = avg13[11:9];

  always_comb begin
    temp_nx = temp;
    if (c > temp && avg13 >= ({1'b0, c, 9'd0} + 13'(HYST)))
      temp_nx = c;
    else if (c < temp && (avg13 + 13'(HYST)) < {1'b0, temp, 9'd0})
      temp_nx = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sclk_hi    <= 1'b0;
      bit_cnt    <= '0;
      sr         <= '0;
      smp_cnt    <= '0;
      accum      <= '0;
      temp       <= '0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= (state == UPDATE);
      if (state == CS_SETUP || state == SHIFT || state == CS_HOLD)
        div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;
      if (state == SHIFT) begin
        if (div_last) begin
          sclk_hi <= !sclk_hi;
          // sclk rises on this edge: capture; leading zeros fall off the top of sr
          if (!sclk_hi) sr <= {sr[10:0], miso};
          else          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        sclk_hi <= 1'b0;
        bit_cnt <= '0;
      end
      if (state == ACCUM) begin
        accum   <= accum + {2'b00, sr};
        smp_cnt <= smp_cnt + 1'b1;
      end
      if (state == UPDATE) begin
        temp    <= temp_nx;
        accum   <= '0;
        smp_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_temp_adc_encoder.sv
// Scoreboard bench: an ADC model serves directed then random words, a monitor
// rebuilds each frame's sample, predicts temp from the averaging rules and checks.
module tb_temp_adc_encoder;

  localparam int CD = 2;
  localparam int SP = 34 * CD + 8;
  localparam int HY = 16;
  localparam int NDIR = 36;
  localparam logic [15:0] DIR [NDIR] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0000,   // all zero -> 0
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,   // leading ones ignored -> 7
    16'd1200, 16'd1200, 16'd1200, 16'd1200,   // settle at 2
    16'd1551, 16'd1551, 16'd1551, 16'd1551,   // one below rising threshold
    16'd1552, 16'd1552, 16'd1552, 16'd1552,   // rising threshold -> 3
    16'd1520, 16'd1520, 16'd1520, 16'd1520,   // falling edge, held at 3
    16'd1519, 16'd1519, 16'd1519, 16'd1519,   // falling threshold -> 2
    16'd1552, 16'd1552, 16'd1552, 16'd1552,   // back to 3
    16'd1500, 16'd1500, 16'd1540, 16'd1540    // mixed, avg 1520 -> 3
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       miso;
  logic       sclk, cs_n, temp_valid, busy;
  logic [2:0] temp;

  int errors = 0, checks = 0;

  temp_adc_encoder #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .HYST(HY)) dut (
    .clk(clk), .rst_n(rst_n), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .temp(temp), .temp_valid(temp_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_temp(input int avg, input int cur);
    int code = avg / 512;
    if (code > cur && avg >= code * 512 + HY) return code;
    if (code < cur && avg + HY < cur * 512) return code;
    return cur;
  endfunction

  // ADC model: a word is latched at cs_n fall, shifted MSB first on sclk falls
  logic [15:0] cur_word = '0;
  int didx = 0, rbase = 0, rleft = 0;
  int falls = 0, base_f = 0, fb;

  always @(negedge cs_n) begin
    int s;
    if (didx < NDIR) cur_word = DIR[didx];
    else begin
      if (rleft == 0) begin
        rbase = int'($urandom_range(0, 7)) * 512 + int'($urandom_range(0, 48)) - 24;
        rleft = 4;
      end
      s = rbase + int'($urandom_range(0, 6)) - 3;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      cur_word = {4'($urandom_range(0, 15)), 12'(s)};
      rleft--;
    end
    didx++;
    base_f = falls;
  end

  always @(negedge sclk) falls++;

  always_comb begin
    fb = falls - base_f;
    miso = (fb >= 0 && fb < 16) ? cur_word[15 - fb] : 1'b0;
  end

  // Monitor: owns the reference model and the expectation queue
  logic [2:0] exp_q[$];
  int win[$];
  int mtemp, temp_last, cyc, f_start, last_start, last_valid, rises;
  int n_frames = 0, n_valid = 0;
  bit start_ok, valid_ok, in_frame, prev_valid;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); win.delete();
      mtemp = 0; temp_last = 0; prev_valid = 0;
      start_ok = 0; valid_ok = 0; in_frame = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0;
    end else begin
      cyc++;
      chk("busy_mirror", busy, !cs_n);
      if (prev_cs && !cs_n) begin
        if (start_ok) chk("start_spacing", cyc - last_start, SP);
        last_start = cyc; start_ok = 1;
        f_start = cyc; rises = 0; in_frame = 1;
      end
      if (!cs_n && sclk && !prev_sclk) rises++;
      if (!prev_cs && cs_n && in_frame) begin
        int sum;
        chk("frame_len", cyc - f_start, 34 * CD);
        chk("sclk_rises", rises, 16);
        in_frame = 0;
        n_frames++;
        win.push_back(int'(cur_word[11:0]));
        if (win.size() == 4) begin
          sum = win[0] + win[1] + win[2] + win[3];
          mtemp = ref_temp(sum / 4, mtemp);
          exp_q.push_back(3'(mtemp));
          win.delete();
        end
      end
      if (temp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_temp_valid", 1, 0);
        else chk("temp", temp, exp_q.pop_front());
        chk("valid_width", prev_valid, 0);
        if (valid_ok) chk("valid_spacing", cyc - last_valid, 4 * SP);
        last_valid = cyc; valid_ok = 1;
        n_valid++;
      end else begin
        chk("temp_hold", temp, temp_last);
      end
      temp_last = temp;
      prev_valid = temp_valid;
      prev_cs = cs_n;
      prev_sclk = sclk;
    end
  end

  task automatic wait_valid(input int target, input int budget);
    int k = 0;
    while (n_valid < target && k < budget) begin @(negedge clk); k++; end
    if (n_valid < target) chk("wait_valid_timeout", n_valid, target);
  endtask

  initial begin
    int k, base;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_temp", temp, 0);
    chk("rst_temp_valid", temp_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // 9 directed windows then 10 random windows
    wait_valid(19, 20 * 4 * SP + 200);

    // Reset in bit 9 of the 3rd frame of a fresh window, while sclk is high
    base = n_frames + 2;
    k = 0;
    while (n_frames < base && k < 4 * SP) begin @(negedge clk); k++; end
    while (cs_n && k < 6 * SP) begin @(negedge clk); k++; end
    while (!(rises == 9 && sclk) && k < 8 * SP) begin @(negedge clk); k++; end
    chk("midframe_reached", (rises == 9 && sclk) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", cs_n, 1);
    chk("async_sclk", sclk, 0);
    chk("async_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("rst2_temp", temp, 0);
    chk("rst2_temp_valid", temp_valid, 0);
    rst_n = 1'b1;

    base = n_valid;
    wait_valid(base + 6, 7 * 4 * SP + 200);
    repeat (4) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temp_adc_encoder.md
Name: temp_adc_encoder

Overview:
Producer side of the 3-bit temperature code bus that the fan and alarm decoders consume.
- Acts as SPI master to a 12-bit serial ADC on the temperature sensor.
- Averages four conversions and quantizes the average to temp[2:0] (0 = coldest, 7 = hottest), with hysteresis at every code boundary.
- Sits between the sensor Pmod pins and the temperature decode/control logic in the top level.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (≥1)
SAMPLE_PERIOD, 1000, clk cycles between conversion start ticks (must be ≥ 34*CLK_DIV+8)
HYST, 16, hysteresis in ADC counts applied at code boundaries (< 256)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
miso  input  1  ADC serial data, MSB first
sclk  output  1  ADC serial clock, idles low
cs_n  output  1  ADC chip select, active low
temp  output  3  quantized temperature code
temp_valid  output  1  one-cycle pulse when temp is re-evaluated
busy  output  1  high while cs_n is low

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: sclk=0, cs_n=1, temp=0, temp_valid=0, busy=0. Tick timer, bit counter, sample counter and 14-bit accumulator all clear to 0.
- Tick timer:
  - Free-running, counts 0..SAMPLE_PERIOD-1 and wraps.
  - Asserts an internal start tick when it reaches SAMPLE_PERIOD-1.
  - A tick arriving outside IDLE is dropped.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM, UPDATE.
- IDLE: on start tick, go to CS_SETUP. cs_n falls on the next edge.
- CS_SETUP: CLK_DIV cycles with cs_n=0 and sclk=0, then go to SHIFT.
- SHIFT: 16 sclk periods of 2*CLK_DIV cycles each, low half first.
  - miso is sampled on the clk edge where sclk rises.
  - Bits are shifted in MSB first.
  - The first 4 bits are the ADC's leading zeros and are discarded. Bits 5..16 form sample[11:0].
  - After the 16th high half, sclk returns to 0 and the FSM goes to CS_HOLD.
- CS_HOLD: CLK_DIV cycles with cs_n=0, then cs_n=1 and go to ACCUM.
- Frame length: cs_n low for exactly 34*CLK_DIV cycles; busy mirrors ~cs_n.
- ACCUM: one cycle.
  - accum += sample; sample counter increments.
  - If the counter was 3, go to UPDATE; otherwise go to IDLE.
- UPDATE: one cycle, then go to IDLE.
  - avg = accum[13:2]; c = avg[11:9].
  - If c > temp and avg ≥ (c<<9)+HYST: temp ← c.
  - If c < temp and avg+HYST < (temp<<9): temp ← c.
  - Otherwise temp is unchanged.
  - temp_valid=1 in the following cycle whether or not temp changed.
  - Accumulator and sample counter clear.
- Widths: all comparisons are unsigned, at least 13 bits wide so avg+HYST does not overflow. Multi-code jumps update directly to c; there is no single-step limit.
- temp changes only on the cycle temp_valid asserts and is otherwise held.
- Reset mid-frame:
  - cs_n=1 and sclk=0 immediately (asynchronous).
  - The partial sample and accumulator are discarded.
  - After release, the first update needs four fresh conversions.
- miso is treated as synchronous to clk; the ADC's sclk is slow enough that no extra synchronizer is required inside this block.

Test Plan:
1. ADC model returns 0x000 constantly, CLK_DIV=2, SAMPLE_PERIOD=100 -> cs_n low exactly 68 clk per frame, 16 sclk rising edges per frame; after 4th frame temp_valid pulses once with temp=0.
2. ADC returns 0xFFF from reset -> after 4th frame temp=7, temp_valid one cycle; leading 4 bits forced to 1 by the model do not affect the result (temp still 7, sample=0xFFF).
3. Rising hysteresis from temp=2 (avg 1200 established), HYST=16 -> avg 1551 keeps temp=2; avg 1552 gives temp=3.
4. Falling hysteresis from temp=3 -> avg 1520 keeps temp=3; avg 1519 gives temp=2; mixed samples 1500,1500,1540,1540 (avg 1520) keep temp=3.
5. Assert rst_n low during SHIFT bit 9 of the 3rd frame -> cs_n=1, sclk=0 same cycle; after release, no temp_valid until 4 complete new frames; temp=0 meanwhile.
6. Set SAMPLE_PERIOD=34*CLK_DIV+8 (minimum) -> no tick is dropped; conversions start exactly SAMPLE_PERIOD cycles apart; temp_valid pulses every 4*SAMPLE_PERIOD cycles.
